// File: rtl/key_search_pkg.sv
// key_search_pkg: shared types for the RC4 key-search requester.
//   state_t        controller FSM states
//   KEY_W_DEFAULT  default key width; matches the key counter output
package key_search_pkg;
  localparam int KEY_W_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_DEC,
    ADVANCE,
    WAIT_KC,
    SETTLE,
    FOUND,
    FAILED
  } state_t;
endpackage

// File: rtl/key_search_ctrl_dec_watchdog.sv
// dec_watchdog: bounds how long the controller waits for the decrypt core.
//   clk, rst_n  clock, synchronous active-low reset
//   clr         restart the count at 0 (asserted the cycle before the wait)
//   en          count this cycle (high while waiting on the core)
//   expire      high in the waiting cycle where the count reaches DEC_TMO-1
// DEC_TMO = 0 disables the watchdog entirely.
module dec_watchdog #(
  parameter int DEC_TMO = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = (DEC_TMO > 0) ? $clog2(DEC_TMO + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)               cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expire)   cnt <= cnt + 1'b1;
  end

  generate
    if (DEC_TMO == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      assign expire = en && (cnt == CW'(DEC_TMO - 1));
    end
  endgenerate
endmodule

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: requester side of the key-counter handshake for the RC4
// brute-force search. Tries one key per decrypt attempt, steps the key counter
// on failure, stops on the first valid plaintext or on key-space exhaustion.
//   clk, rst_n            clock, synchronous active-low reset
//   go                    start search (sampled in IDLE only)
//   kc_start (out)        one-cycle pulse advancing the key counter
//   kc_finish, kc_tak     counter reply / tried-all-keys (sticky)
//   kc_key                current key from the counter
//   dec_start, dec_key    decrypt launch pulse and the key it uses
//   dec_done, dec_valid   decrypt completion and plaintext-check result
//   busy, found, failed   status; found/failed are sticky until reset
//   tmo_err               decrypt-core watchdog fired (also sets failed)
//   found_key, attempts   winning key; number of dec_start pulses (saturating)
module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEFAULT,
  parameter int ATT_W   = 25,
  parameter int DEC_TMO = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  output logic             kc_start,
  input  logic             kc_finish,
  input  logic             kc_tak,
  input  logic [KEY_W-1:0] kc_key,
  output logic             dec_start,
  output logic [KEY_W-1:0] dec_key,
  input  logic             dec_done,
  input  logic             dec_valid,
  output logic             busy,
  output logic             found,
  output logic             failed,
  output logic             tmo_err,
  output logic [KEY_W-1:0] found_key,
  output logic [ATT_W-1:0] attempts
);
  state_t state_q, state_d;
  logic   wd_expire;
  logic   tmo_hit;

  dec_watchdog #(.DEC_TMO(DEC_TMO)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == LAUNCH),
    .en     (state_q == WAIT_DEC),
    .expire (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE:     if (go) state_d = LAUNCH;
      LAUNCH:   state_d = WAIT_DEC;
      WAIT_DEC: begin
        // a completion in the expiry cycle still counts
        if (dec_done)       state_d = dec_valid ? FOUND : ADVANCE;
        else if (wd_expire) begin
          state_d = FAILED;
          tmo_hit = 1'b1;
        end
      end
      ADVANCE:  state_d = WAIT_KC;
      // a sticky finish already present on entry is taken immediately
      WAIT_KC:  if (kc_finish) state_d = kc_tak ? FAILED : SETTLE;
      // counter presents its new key the cycle after finish
      SETTLE:   state_d = LAUNCH;
      default:  state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with
  // the state it belongs to; LAUNCH and ADVANCE last exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dec_start <= 1'b0;
      kc_start  <= 1'b0;
      busy      <= 1'b0;
      found     <= 1'b0;
      failed    <= 1'b0;
      tmo_err   <= 1'b0;
      dec_key   <= '0;
      found_key <= '0;
      attempts  <= '0;
    end else begin
      state_q   <= state_d;
      dec_start <= (state_d == LAUNCH);
      kc_start  <= (state_d == ADVANCE);
      busy      <= !(state_d inside {IDLE, FOUND, FAILED});
      found     <= (state_d == FOUND);
      failed    <= (state_d == FAILED);
      if (tmo_hit) tmo_err <= 1'b1;
      if (state_d == LAUNCH) begin
        dec_key <= kc_key;
        if (attempts != '1) attempts <= attempts + 1'b1;
      end
      if (state_q == WAIT_DEC && state_d == FOUND) found_key <= dec_key;
    end
  end
endmodule

// File: tb/tb_key_search_ctrl.sv
module tb_key_search_ctrl;
  localparam int KW = 24, AW = 25, TMO = 16;

  logic          clk = 1'b0, rst_n = 1'b0, go = 1'b0;
  logic          kc_finish = 1'b0, kc_tak = 1'b0, dec_done = 1'b0, dec_valid = 1'b0;
  logic [KW-1:0] kc_key = '0;
  logic          kc_start, dec_start, busy, found, failed, tmo_err;
  logic [KW-1:0] dec_key, found_key;
  logic [AW-1:0] attempts;

  key_search_ctrl #(.KEY_W(KW), .ATT_W(AW), .DEC_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .kc_start(kc_start), .kc_finish(kc_finish),
    .kc_tak(kc_tak), .kc_key(kc_key), .dec_start(dec_start), .dec_key(dec_key),
    .dec_done(dec_done), .dec_valid(dec_valid), .busy(busy), .found(found),
    .failed(failed), .tmo_err(tmo_err), .found_key(found_key), .attempts(attempts)
  );

  always #5 clk = ~clk;

  // environment configuration
  int unsigned upper = 0, vkey = 0, lat_max = 1;
  bit          no_resp = 0;
  // counter and decrypt-core models
  bit          start_prev = 0, bump = 0;
  int          dly = 0;
  logic [KW-1:0] dkey = '0;
  // reference model
  bit          m_busy = 0, m_found = 0, m_failed = 0, m_tmo = 0, dw_act = 0, kw_act = 0;
  logic [KW-1:0] m_fkey = '0;
  int          n_ds = 0, n_ks = 0, ds_due = 0, ks_due = 0, wcnt = 0;
  int          cyc_cnt = 0, t_ds = 0, t_fail = 0;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Per-cycle: compare DUT outputs, drive next inputs, advance the model.
  initial forever begin
    @(negedge clk);
    cyc_cnt++;
    chk("dec_start", dec_start, ds_due == 1);
    chk("kc_start", kc_start, ks_due == 1);
    chk("busy", busy, m_busy);
    chk("found", found, m_found);
    chk("failed", failed, m_failed);
    chk("tmo_err", tmo_err, m_tmo);
    chk("found_key", found_key, m_fkey);
    if (dec_start) begin
      n_ds++;
      t_ds = cyc_cnt;
      chk("dec_key", dec_key, kc_key);
    end
    if (kc_start) n_ks++;
    if (failed && t_fail == 0) t_fail = cyc_cnt;
    chk("attempts", attempts, AW'(n_ds));
    if (ds_due > 0) ds_due--;
    if (ks_due > 0) ks_due--;

    // key counter: finish one cycle after start, key+1 the cycle after that
    if (bump) begin kc_key = kc_key + 1'b1; bump = 0; end
    if (!kc_tak) kc_finish = 1'b0;
    if (start_prev) begin
      kc_finish = 1'b1;
      if (kc_key == KW'(upper)) kc_tak = 1'b1;
      else bump = 1;
    end
    start_prev = kc_start;

    // decrypt core: answers after a random latency; dec_valid noise otherwise
    dec_done  = 1'b0;
    dec_valid = 1'($urandom_range(0, 1));
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        dec_done  = 1'b1;
        dec_valid = (dkey == KW'(vkey));
      end
    end
    if (dec_start) begin
      dkey = dec_key;
      dly  = no_resp ? 0 : int'($urandom_range(1, lat_max));
    end

    if (!rst_n) begin
      kc_key = '0; kc_finish = 0; kc_tak = 0; bump = 0; start_prev = 0;
      dly = 0; dec_done = 0;
      m_busy = 0; m_found = 0; m_failed = 0; m_tmo = 0; m_fkey = '0;
      n_ds = 0; n_ks = 0; ds_due = 0; ks_due = 0; dw_act = 0; kw_act = 0; t_fail = 0;
    end else begin
      if (dw_act) begin
        wcnt++;
        if (dec_done) begin
          dw_act = 0;
          if (dec_valid) begin m_found = 1; m_busy = 0; m_fkey = dkey; end
          else ks_due = 1;
        end else if (wcnt == TMO) begin
          dw_act = 0; m_failed = 1; m_tmo = 1; m_busy = 0;
        end
      end
      if (dec_start) begin dw_act = 1; wcnt = 0; end
      if (kw_act && kc_finish) begin
        kw_act = 0;
        if (kc_tak) begin m_failed = 1; m_busy = 0; end
        else ds_due = 2;
      end
      if (kc_start) kw_act = 1;
      if (!m_busy && !m_found && !m_failed && go) begin m_busy = 1; ds_due = 1; end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic configure(input int unsigned up, input int unsigned vk, input bit nr,
                           input int unsigned lm);
    upper = up; vkey = vk; no_resp = nr; lat_max = lm;
  endtask

  task automatic do_reset();
    rst_n = 0; go = 0; cyc(2); rst_n = 1; cyc(1);
  endtask

  // Pulse go, let the search run with go noise, then check the end result
  // computed directly from the key range and the single valid key.
  task automatic search();
    bit efound;
    go = 1; cyc(1);
    for (int i = 0; i < 4000 && !(m_found || m_failed); i++) begin
      go = 1'($urandom_range(0, 1));
      cyc(1);
    end
    go = 0; cyc(4);
    chk("search_ended", m_found || m_failed, 1);
    if (no_resp) begin
      chk("end_tmo", tmo_err, 1);
      chk("end_attempts", attempts, 1);
    end else begin
      efound = (vkey <= upper);
      chk("end_found", found, efound);
      chk("end_failed", failed, !efound);
      chk("end_attempts", attempts, efound ? vkey + 1 : upper + 1);
      chk("end_kc_starts", n_ks, efound ? vkey : upper + 1);
      if (efound) chk("end_found_key", found_key, vkey);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(1);
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_attempts", attempts, 0);

    // first key valid: one attempt, no counter step
    configure(0, 0, 0, 4); do_reset(); search();
    chk("k0_attempts", attempts, 25'd1);
    chk("k0_kcs", n_ks, 0);
    chk("k0_found_key", found_key, 24'h000000);

    // only key 3 valid in 0..4
    configure(4, 3, 0, 6); do_reset(); search();
    chk("k3_attempts", attempts, 25'd4);
    chk("k3_kcs", n_ks, 3);
    chk("k3_found_key", found_key, 24'h000003);

    // no valid key in 0..2: exhaustion on the third step
    configure(2, 99, 0, 5); do_reset(); search();
    chk("ex_attempts", attempts, 25'd3);
    chk("ex_kcs", n_ks, 3);
    chk("ex_failed", failed, 1'b1);
    chk("ex_found", found, 1'b0);

    // silent decrypt core: watchdog fires after 16 waiting cycles
    configure(5, 0, 1, 1); do_reset(); search();
    chk("tmo_failed", failed, 1'b1);
    chk("tmo_latency", t_fail - t_ds, 17);

    // reset while waiting on the counter, then a clean restart
    configure(10, 99, 0, 3); do_reset();
    go = 1; cyc(1); go = 0;
    for (int i = 0; i < 200 && n_ks == 0; i++) cyc(1);
    chk("rst_reached_wait_kc", n_ks, 1);
    rst_n = 0; cyc(1); rst_n = 1; cyc(2);
    chk("rst_attempts", attempts, 25'd0);
    chk("rst_busy", busy, 1'b0);
    search();
    chk("rst_restart_attempts", attempts, 25'd11);

    // randomized searches, latencies up to the watchdog limit
    for (int r = 0; r < 20; r++) begin
      configure($urandom_range(0, 12), $urandom_range(0, 15), 0, $urandom_range(1, TMO));
      do_reset();
      search();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
